boss_bullet_pool: RTL and testbench
===================================

# boss_bullet_pool

Multi-slot projectile engine for the final boss. It holds up to NUM_BULLETS independent bullets, launches them from the boss position under a fire-request handshake with a cooldown, and advances them once per frame tick. It renders all live bullets to the VGA pixel stream and reports registered, per-slot-consumed collisions with the player. It sits between the boss controller, the VGA compositor and the player health logic.

## Interface
- NUM_BULLETS, 4: number of bullet slots (1–16).
- BULLET_W, 5: bullet width in pixels.
- BULLET_H, 5: bullet height in pixels.
- SPEED, 2: horizontal pixels moved leftward per tick (≥1).
- COOLDOWN, 16: ticks between accepted shots (≥1).
- CHAR_W, 10: player hitbox width.
- CHAR_H, 10: player hitbox height.
- Y_MAX, 300: lower playfield bound for vertical travel.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle frame-rate move strobe.
- fire_req  in  1  level request to launch a bullet.
- fire_ack  out  1  one-cycle pulse: shot accepted.
- start_x  in  10  launch X, sampled at acceptance.
- start_y  in  9  launch Y, sampled at acceptance.
- x  in  10  VGA scan X.
- y  in  9  VGA scan Y.
- char_x  in  10  player X.
- char_y  in  9  player Y.
- bullet_pix  out  1  scan pixel lies inside any live bullet.
- bullet_r, bullet_g, bullet_b  out  8 each  bullet colour, constant 8'h00.
- bullet_hit  out  1  registered pulse: at least one bullet overlapped the player.
- active_count  out  $clog2(NUM_BULLETS+1)  number of live slots.

## Operation
- Reset: all slots inactive; cooldown = 0; fire_ack = 0; bullet_hit = 0; active_count = 0.
- Acceptance happens on a clk edge where fire_req=1, cooldown=0 and at least one slot is free.
  - The block allocates the lowest-index free slot and loads x=start_x, y=start_y.
  - Cooldown loads COOLDOWN.
- If fire_req=1 while cooldown≠0 or all slots are full, the request is ignored with no queuing. The requester keeps holding fire_req.
- Cooldown decrements by 1 on each tick while nonzero and saturates at 0.
- Movement on tick, for each live slot:
  - If x ≤ SPEED, the slot is freed. This is the left-edge exit and causes no underflow.
  - Otherwise x ← x − SPEED.
- A slot allocated on an edge where tick=1 is not moved on that edge.
- Overlap test, per slot, half-open: bx < char_x+CHAR_W, bx+BULLET_W > char_x, by < char_y+CHAR_H, by+BULLET_H > char_y. All sums are computed at 11 bits.
- Hit:
  - bullet_hit is registered as the OR of the live-slot overlaps.
  - Each overlapping slot is freed on the same edge; a bullet hits at most once.
  - If a slot both hits and exits on the same edge, it is freed and the hit is still reported.
- bullet_pix is combinational: OR over live slots of x∈[bx,bx+BULLET_W) and y∈[by,by+BULLET_H).
- active_count is the registered popcount of the slot active bits.

## Timing
- Shot latency: fire_ack and the new slot's active bit both rise at the edge after fire_req is sampled. bullet_pix can show the bullet from that cycle onward.
- Maximum fire rate: one shot per COOLDOWN ticks.
- Collision latency: overlap in cycle N gives bullet_hit=1 in cycle N+1, lasting one cycle per hit event.
- Asynchronous reset mid-flight clears all state immediately, with no trailing pulses.

## Configuration
- BOSS_BULLET_AIM_EN defined: each slot stores a dy ∈ {−1,0,+1} latched at acceptance as sign(char_y − start_y).
  - On tick, y ← y+dy.
  - The slot is freed if y=0 and dy=−1, or if y+BULLET_H ≥ Y_MAX and dy=+1.
- BOSS_BULLET_AIM_EN undefined: y stays fixed at start_y. No dy storage or vertical bounds logic is built, and behaviour is horizontal-only.

## Structure
- Package boss_pkg holds:
  - the slot struct typedef {active, x[9:0], y[8:0], dy (under the macro)};
  - coordinate width constants;
  - the colour constant.
- Sub-module boss_bullet_slot: one slot's state register, movement, bounds check, overlap and pixel test. It has load, free and tick inputs and overlap and pix outputs.
- The top level holds the priority allocator, cooldown counter, hit/pix reduction and popcount.

## Test plan
- Reset, then fire_req=1 with start=(150,100), char far away → fire_ack at the next edge; slot0 at x=150; after 10 ticks, x=130.
- fire_req held high, COOLDOWN=16, NUM_BULLETS=4 → acks 16 ticks apart; the 5th request is ignored until a slot frees; active_count saturates at 4.
- Bullet at x=4 with SPEED=2 → x=2 after the next tick; freed on the following tick; no wrap to 1023.
- Player at (100,100), bullet launched at (112,100) → after 1 tick x=110, no hit; after 2 ticks x=108, bullet_hit pulses once and the slot is freed; active_count decrements.
- Simultaneous tick and acceptance → the new slot stays at start_x while existing slots move by SPEED.
- With BOSS_BULLET_AIM_EN: start_y=100, char_y=150 → y=105 after 5 ticks. Assert reset mid-flight → all outputs return to 0 immediately.

Source files
------------

// File: rtl/boss_pkg.sv
// boss_pkg: shared types and constants for the boss bullet pool.
//   slot_t        : per-slot state {active, x, y, dy (aim builds only)}
//   X_W / Y_W     : screen coordinate widths (10-bit X, 9-bit Y)
//   SUM_W         : width used for all overlap / pixel sums, so nothing wraps
//   BULLET_COLOUR : fixed bullet colour for every channel
//   popcount16    : live-slot counter helper (pools of up to 16 slots)
// Optional feature macro: BOSS_BULLET_AIM_EN (vertical aiming, dy per slot).
package boss_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int SUM_W = 11;

  localparam logic [7:0] BULLET_COLOUR = 8'h00;

`ifdef BOSS_BULLET_AIM_EN
  // dy is a 2-bit two's-complement step: -1, 0 or +1 pixel per tick.
  localparam logic [1:0] DY_UP   = 2'b11;
  localparam logic [1:0] DY_NONE = 2'b00;
  localparam logic [1:0] DY_DOWN = 2'b01;
`endif

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
`ifdef BOSS_BULLET_AIM_EN
    logic [1:0]     dy;
`endif
  } slot_t;

`ifdef BOSS_BULLET_AIM_EN
  // sign(target - origin) as a dy step.
  function automatic logic [1:0] aim_dir(input logic [Y_W-1:0] target,
                                         input logic [Y_W-1:0] origin);
    if (target > origin)      return DY_DOWN;
    else if (target < origin) return DY_UP;
    else                      return DY_NONE;
  endfunction
`endif

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/boss_bullet_slot.sv
// boss_bullet_slot: one projectile slot.
//   load / load_x / load_y (/ load_dy) : occupy the slot at a new position
//   free                               : release the slot (hit consumed)
//   tick                               : frame move strobe
//   scan_x / scan_y                    : VGA scan position for the pixel test
//   char_x / char_y                    : player hitbox origin
//   overlap                            : live and intersecting the player (comb)
//   pix                                : live and covering the scan pixel (comb)
//   active_next                        : active bit as it will be after this edge
// Optional feature macro: BOSS_BULLET_AIM_EN.
module boss_bullet_slot
  import boss_pkg::*;
#(
  parameter int BULLET_W = 5,
  parameter int BULLET_H = 5,
  parameter int SPEED    = 2,
  parameter int CHAR_W   = 10,
  parameter int CHAR_H   = 10,
  parameter int Y_MAX    = 300
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
`ifdef BOSS_BULLET_AIM_EN
  input  logic [1:0]     load_dy,
`endif
  input  logic           tick,
  input  logic           free,
  input  logic [X_W-1:0] scan_x,
  input  logic [Y_W-1:0] scan_y,
  input  logic [X_W-1:0] char_x,
  input  logic [Y_W-1:0] char_y,
  output logic           overlap,
  output logic           pix,
  output logic           active_next
);

  slot_t state;
  slot_t nxt;

  // The allocator only loads an idle slot, so load never races free/move.
  always_comb begin
    nxt = state;
    if (load) begin
      nxt.active = 1'b1;
      nxt.x      = load_x;
      nxt.y      = load_y;
`ifdef BOSS_BULLET_AIM_EN
      nxt.dy     = load_dy;
`endif
    end else if (state.active) begin
      if (free) begin
        nxt.active = 1'b0;
      end else if (tick) begin
        // Exit at the left edge instead of subtracting past zero.
        if (state.x <= X_W'(SPEED)) nxt.active = 1'b0;
        else                        nxt.x      = state.x - X_W'(SPEED);
`ifdef BOSS_BULLET_AIM_EN
        if (state.dy == DY_UP && state.y == '0)
          nxt.active = 1'b0;
        else if (state.dy == DY_DOWN &&
                 ({2'b0, state.y} + SUM_W'(BULLET_H) >= SUM_W'(Y_MAX)))
          nxt.active = 1'b0;
        else
          nxt.y = state.y + {{(Y_W-2){state.dy[1]}}, state.dy};
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= '0;
    else       state <= nxt;
  end

  assign active_next = nxt.active;

  // All comparisons are done at SUM_W bits so right/bottom edges never wrap.
  logic [SUM_W-1:0] bx, by, cx, cy, sx, sy;
  assign bx = {1'b0, state.x};
  assign by = {2'b0, state.y};
  assign cx = {1'b0, char_x};
  assign cy = {2'b0, char_y};
  assign sx = {1'b0, scan_x};
  assign sy = {2'b0, scan_y};

  assign overlap = state.active &&
                   (bx < cx + SUM_W'(CHAR_W)) && (bx + SUM_W'(BULLET_W) > cx) &&
                   (by < cy + SUM_W'(CHAR_H)) && (by + SUM_W'(BULLET_H) > cy);

  assign pix = state.active &&
               (sx >= bx) && (sx < bx + SUM_W'(BULLET_W)) &&
               (sy >= by) && (sy < by + SUM_W'(BULLET_H));

endmodule

// File: rtl/boss_bullet_pool.sv
// boss_bullet_pool: multi-slot boss projectile engine.
//   clk, reset (async, active-high)
//   tick                 : frame move strobe
//   fire_req / fire_ack  : launch handshake (see below)
//   start_x / start_y    : launch position, sampled at acceptance
//   x / y                : VGA scan position
//   char_x / char_y      : player hitbox origin
//   bullet_pix           : scan pixel lies inside a live bullet (comb)
//   bullet_r/g/b         : bullet colour
//   bullet_hit           : registered pulse, one or more bullets hit the player
//   active_count         : registered number of live slots
// Optional feature macro: BOSS_BULLET_AIM_EN (per-slot vertical aiming).
//
// Handshake: fire_req is a level request. A shot is accepted on any edge where
// fire_req=1, the cooldown is zero and a slot is idle; fire_ack pulses for the
// following cycle. Refused requests are dropped, not queued; the requester
// simply keeps fire_req high until it sees fire_ack.
module boss_bullet_pool
  import boss_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int BULLET_W    = 5,
  parameter int BULLET_H    = 5,
  parameter int SPEED       = 2,
  parameter int COOLDOWN    = 16,
  parameter int CHAR_W      = 10,
  parameter int CHAR_H      = 10,
  parameter int Y_MAX       = 300
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tick,
  input  logic                               fire_req,
  output logic                               fire_ack,
  input  logic [9:0]                         start_x,
  input  logic [8:0]                         start_y,
  input  logic [9:0]                         x,
  input  logic [8:0]                         y,
  input  logic [9:0]                         char_x,
  input  logic [8:0]                         char_y,
  output logic                               bullet_pix,
  output logic [7:0]                         bullet_r,
  output logic [7:0]                         bullet_g,
  output logic [7:0]                         bullet_b,
  output logic                               bullet_hit,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count
);

  localparam int CNT_W = $clog2(NUM_BULLETS+1);
  localparam int CD_W  = $clog2(COOLDOWN+1);

  logic [NUM_BULLETS-1:0] active_next;
  logic [NUM_BULLETS-1:0] active_vec;
  logic [NUM_BULLETS-1:0] free_mask;
  logic [NUM_BULLETS-1:0] load_vec;
  logic [NUM_BULLETS-1:0] overlap_vec;
  logic [NUM_BULLETS-1:0] pix_vec;
  logic [CD_W-1:0]        cooldown;
  logic                   accept;

  // active_count always tracks the slots' active bits, so its register is
  // also the current occupancy seen by the allocator.
  logic [NUM_BULLETS-1:0] active_q;
  assign active_vec = active_q;
  assign free_mask  = ~active_vec;
  assign accept     = fire_req && (cooldown == '0) && (|free_mask);
  // x & -x isolates the lowest idle slot.
  assign load_vec   = accept ? (free_mask & (~free_mask + 1'b1)) : '0;

`ifdef BOSS_BULLET_AIM_EN
  logic [1:0] launch_dy;
  assign launch_dy = aim_dir(char_y, start_y);
`endif

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    boss_bullet_slot #(
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H),
      .SPEED    (SPEED),
      .CHAR_W   (CHAR_W),
      .CHAR_H   (CHAR_H),
      .Y_MAX    (Y_MAX)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (load_vec[i]),
      .load_x      (start_x),
      .load_y      (start_y),
`ifdef BOSS_BULLET_AIM_EN
      .load_dy     (launch_dy),
`endif
      .tick        (tick),
      .free        (overlap_vec[i]),
      .scan_x      (x),
      .scan_y      (y),
      .char_x      (char_x),
      .char_y      (char_y),
      .overlap     (overlap_vec[i]),
      .pix         (pix_vec[i]),
      .active_next (active_next[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cooldown     <= '0;
      fire_ack     <= 1'b0;
      bullet_hit   <= 1'b0;
      active_q     <= '0;
      active_count <= '0;
    end else begin
      fire_ack     <= accept;
      bullet_hit   <= |overlap_vec;
      active_q     <= active_next;
      active_count <= CNT_W'(popcount16(16'(active_next)));
      if (accept)
        cooldown <= CD_W'(COOLDOWN);
      else if (tick && cooldown != '0)
        cooldown <= cooldown - 1'b1;
    end
  end

  assign bullet_pix = |pix_vec;
  assign bullet_r   = BULLET_COLOUR;
  assign bullet_g   = BULLET_COLOUR;
  assign bullet_b   = BULLET_COLOUR;

endmodule

// File: tb/tb_boss_bullet_pool.sv
// Self-checking bench for boss_bullet_pool (default parameters).
module tb_boss_bullet_pool;

  localparam int NB   = 4;
  localparam int CD   = 16;
  localparam int SPD  = 2;
  localparam int BW   = 5;
  localparam int BH   = 5;
  localparam int CW   = 10;
  localparam int CH   = 10;
  localparam int YMAX = 300;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       tick, fire_req, fire_ack;
  logic [9:0] start_x, x, char_x;
  logic [8:0] start_y, y, char_y;
  logic       bullet_pix, bullet_hit;
  logic [7:0] bullet_r, bullet_g, bullet_b;
  logic [2:0] active_count;

  always #5 clk = ~clk;

  boss_bullet_pool #(
    .NUM_BULLETS (NB), .BULLET_W (BW), .BULLET_H (BH), .SPEED (SPD),
    .COOLDOWN (CD), .CHAR_W (CW), .CHAR_H (CH), .Y_MAX (YMAX)
  ) dut (
    .clk (clk), .reset (reset), .tick (tick), .fire_req (fire_req),
    .fire_ack (fire_ack), .start_x (start_x), .start_y (start_y),
    .x (x), .y (y), .char_x (char_x), .char_y (char_y),
    .bullet_pix (bullet_pix), .bullet_r (bullet_r), .bullet_g (bullet_g),
    .bullet_b (bullet_b), .bullet_hit (bullet_hit), .active_count (active_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- reference model ----------------
  int m_act[NB];
  int m_x[NB];
  int m_y[NB];
  int m_dy[NB];
  int m_cd;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dy[i] = 0;
    end
    m_cd = 0;
  endtask

  function automatic bit m_pix(input int px, input int py);
    bit r = 0;
    for (int i = 0; i < NB; i++)
      if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + BW &&
          py >= m_y[i] && py < m_y[i] + BH) r = 1;
    return r;
  endfunction

  // Returns {ack, hit, count} expected after the coming edge.
  task automatic model_step(input bit fr, input bit tk, input int sx, input int sy,
                            output logic [4:0] e);
    int  n_act[NB];
    int  n_x[NB];
    int  n_y[NB];
    int  n_dy[NB];
    bit  hit, acc;
    int  cnt, cx, cy;
    n_act = m_act; n_x = m_x; n_y = m_y; n_dy = m_dy;
    hit = 0; acc = 0; cnt = 0;
    cx = int'(char_x); cy = int'(char_y);
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] != 0) begin
        if (m_x[i] < cx + CW && m_x[i] + BW > cx && m_y[i] < cy + CH && m_y[i] + BH > cy) begin
          hit = 1; n_act[i] = 0;
        end else if (tk) begin
          if (m_x[i] <= SPD) n_act[i] = 0;
          else n_x[i] = m_x[i] - SPD;
`ifdef BOSS_BULLET_AIM_EN
          if (m_dy[i] == -1 && m_y[i] == 0) n_act[i] = 0;
          else if (m_dy[i] == 1 && m_y[i] + BH >= YMAX) n_act[i] = 0;
          else n_y[i] = m_y[i] + m_dy[i];
`endif
        end
      end
    end
    if (fr && m_cd == 0) begin
      for (int i = 0; i < NB; i++) begin
        if (m_act[i] == 0 && !acc) begin
          acc = 1; n_act[i] = 1; n_x[i] = sx; n_y[i] = sy;
          n_dy[i] = (cy > sy) ? 1 : ((cy < sy) ? -1 : 0);
        end
      end
    end
    if (acc) m_cd = CD;
    else if (tk && m_cd > 0) m_cd = m_cd - 1;
    m_act = n_act; m_x = n_x; m_y = n_y; m_dy = n_dy;
    for (int i = 0; i < NB; i++) cnt += m_act[i];
    e = {acc, hit, 3'(cnt)};
  endtask

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];

  // Drive one cycle; expectation is queued at drive time, compared after the edge.
  task automatic cycle(input bit fr, input bit tk, input int sx, input int sy);
    logic [4:0] e;
    fire_req = fr; tick = tk; start_x = 10'(sx); start_y = 9'(sy);
    model_step(fr, tk, sx, sy, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("sb_ack_hit_cnt", int'({fire_ack, bullet_hit, active_count}), int'(e));
  endtask

  task automatic probe(input string name, input int px, input int py, input bit exp_pix);
    x = 10'(px); y = 9'(py); #1;
    check(name, int'(bullet_pix), int'(exp_pix));
  endtask

  task automatic do_reset(input int cx, input int cy);
    reset = 1'b1; fire_req = 1'b0; tick = 1'b0;
    char_x = 10'(cx); char_y = 9'(cy);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // ---------------- table ----------------
  typedef struct {
    bit fr;
    bit tk;
    bit e_ack;
    int e_cnt;
    int px;
    bit e_pix;
  } vec_t;

  vec_t tbl[15];
  int   acks, max_cnt;

  initial begin
    // Launch at (150,100), then ten ticks: x walks 148..130.
    tbl[0] = '{fr: 1, tk: 0, e_ack: 1, e_cnt: 1, px: 150, e_pix: 1};
    tbl[1] = '{fr: 0, tk: 0, e_ack: 0, e_cnt: 1, px: 149, e_pix: 0};
    for (int k = 1; k <= 10; k++)
      tbl[k+1] = '{fr: 0, tk: 1, e_ack: 0, e_cnt: 1, px: 150 - 2*k, e_pix: 1};
    tbl[12] = '{fr: 0, tk: 0, e_ack: 0, e_cnt: 1, px: 129, e_pix: 0};
    tbl[13] = '{fr: 0, tk: 0, e_ack: 0, e_cnt: 1, px: 134, e_pix: 1};
    tbl[14] = '{fr: 0, tk: 0, e_ack: 0, e_cnt: 1, px: 135, e_pix: 0};

    x = '0; y = '0; start_x = '0; start_y = '0;
    do_reset(600, 100);

    // Reset state.
    check("rst_ack", int'(fire_ack), 0);
    check("rst_hit", int'(bullet_hit), 0);
    check("rst_cnt", int'(active_count), 0);
    check("rst_colour", int'({bullet_r, bullet_g, bullet_b}), 0);
    probe("rst_pix", 150, 100, 0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].fr, tbl[i].tk, 150, 100);
      check("tbl_ack", int'(fire_ack), int'(tbl[i].e_ack));
      check("tbl_cnt", int'(active_count), tbl[i].e_cnt);
      probe("tbl_pix", tbl[i].px, 100, tbl[i].e_pix);
    end

    // Left-edge exit: x=4 -> 2 -> freed, no wrap.
    do_reset(900, 50);
    cycle(1, 0, 4, 50);
    probe("edge_x4", 4, 50, 1);
    cycle(0, 1, 4, 50);
    probe("edge_x2", 2, 50, 1);
    probe("edge_x1", 1, 50, 0);
    check("edge_cnt1", int'(active_count), 1);
    cycle(0, 1, 4, 50);
    check("edge_cnt0", int'(active_count), 0);
    probe("edge_gone", 2, 50, 0);
    probe("edge_nowrap", 1022, 50, 0);

    // Collision: player (100,100), bullet from (112,100).
    do_reset(100, 100);
    cycle(1, 0, 112, 100);
    cycle(0, 1, 112, 100);
    check("hit_x110_none", int'(bullet_hit), 0);
    probe("hit_x110", 110, 100, 1);
    cycle(0, 1, 112, 100);
    check("hit_x108_pending", int'(bullet_hit), 0);
    probe("hit_x108", 108, 100, 1);
    cycle(0, 0, 112, 100);
    check("hit_pulse", int'(bullet_hit), 1);
    check("hit_freed", int'(active_count), 0);
    cycle(0, 0, 112, 100);
    check("hit_once", int'(bullet_hit), 0);

    // Held fire_req: cooldown spacing, saturation at four slots.
    do_reset(900, 400);
    acks = 0; max_cnt = 0;
    for (int c = 0; c < 220; c++) begin
      cycle(1, (c % 2) == 1, 200, 150);
      acks += int'(fire_ack);
      if (int'(active_count) > max_cnt) max_cnt = int'(active_count);
      if (c == 32 || c == 200) check("burst_ack_at", int'(fire_ack), 1);
      if (c == 128) check("burst_full_ignored", int'(fire_ack), 0);
    end
    check("burst_acks", acks, 5);
    check("burst_max_cnt", max_cnt, 4);

    // Acceptance on a tick edge: new slot stays put, old one moves.
    do_reset(900, 50);
    cycle(1, 0, 300, 50);
    for (int k = 0; k < 16; k++) cycle(1, 1, 400, 80);
    probe("simul_old_pre", 268, 50, 1);
    cycle(1, 1, 400, 80);
    check("simul_ack", int'(fire_ack), 1);
    check("simul_cnt", int'(active_count), 2);
    probe("simul_new", 400, 80, 1);
    probe("simul_new_left", 399, 80, 0);
    probe("simul_old", 266, 50, 1);
    probe("simul_old_left", 265, 50, 0);
    probe("simul_model", 266, 50, m_pix(266, 50));

`ifdef BOSS_BULLET_AIM_EN
    // Aimed downward: y 100 -> 105 after five ticks.
    do_reset(900, 150);
    cycle(1, 0, 300, 100);
    for (int k = 0; k < 5; k++) cycle(0, 1, 300, 100);
    probe("aim_y105", 290, 105, 1);
    probe("aim_y104", 290, 104, 0);
`endif

    // Asynchronous reset mid-flight with a hit pending.
    do_reset(100, 100);
    cycle(1, 0, 112, 100);
    cycle(0, 1, 112, 100);
    cycle(0, 1, 112, 100);
    x = 10'd108; y = 9'd100;
    #2 reset = 1'b1;
    #1;
    check("async_ack", int'(fire_ack), 0);
    check("async_hit", int'(bullet_hit), 0);
    check("async_cnt", int'(active_count), 0);
    check("async_pix", int'(bullet_pix), 0);
    @(posedge clk); #1;
    check("async_no_trailing_hit", int'(bullet_hit), 0);
    reset = 1'b0;
    model_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
